// File: rtl/data_buffer_wrapper_pkg.sv
// rtl/data_buffer_wrapper_pkg.sv - shared defaults and read FSM encoding for the data buffer
package data_buffer_wrapper_pkg;
   localparam int WIDTH_DEF = 16;
   localparam int DEPTH_DEF = 8;
   localparam int HOLD_DEF  = 1;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_SHOW = 1'b1
   } rd_state_t;
endpackage

// File: rtl/data_buffer_wrapper_if.sv
// rtl/data_buffer_wrapper_if.sv - producer/display/status signal bundle around the data buffer
interface data_buffer_wrapper_if
   import data_buffer_wrapper_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             data_1_en;
   logic [WIDTH-1:0] data_1;
   logic             rd_tick;
   logic             flush;
   logic [WIDTH-1:0] data_2;
   logic             data_2_valid;
   logic             buffer_full;
   logic             buffer_empty;
   logic [CW-1:0]    count;
   logic             overflow;

   modport master (
      output data_1_en, data_1, rd_tick, flush,
      input  data_2, data_2_valid, buffer_full, buffer_empty, count, overflow
   );

   modport slave (
      input  data_1_en, data_1, rd_tick, flush,
      output data_2, data_2_valid, buffer_full, buffer_empty, count, overflow
   );
endinterface

// File: rtl/data_buffer_wrapper_fifo_mem.sv
// rtl/data_buffer_wrapper_fifo_mem.sv - DEPTH x WIDTH register array, one write port, async read
module data_buffer_wrapper_fifo_mem #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/data_buffer_wrapper.sv
// rtl/data_buffer_wrapper.sv - consumer-side FIFO drained one word per slow tick to the display
module data_buffer_wrapper
   import data_buffer_wrapper_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int HOLD_TICKS = HOLD_DEF
) (
   input logic                   clk,
   input logic                   rst,
   data_buffer_wrapper_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [HW-1:0] HOLD_C  = HW'(HOLD_TICKS);

   rd_state_t        state_q, state_d;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, empty_q, overflow_q, valid_q;
   logic [WIDTH-1:0] data_2_q, rd_data;
   logic [HW-1:0]    hold_q;
   logic             wr_en, pop, hold_inc, drop_valid;

   // Full is judged on registered state, so a slot freed by a same-cycle pop is not reused
   assign wr_en = bus.data_1_en && !full_q;

   data_buffer_wrapper_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .we      (wr_en && !bus.flush),
      .wr_addr (wr_ptr),
      .wr_data (bus.data_1),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            state_q <= R_IDLE;
      else if (bus.flush) state_q <= R_IDLE;
      else                state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.rd_tick) begin
         case (state_q)
            R_IDLE: if (!empty_q) state_d = R_SHOW;
            R_SHOW: if (hold_q == HOLD_C && empty_q) state_d = R_IDLE;
            default: state_d = R_IDLE;
         endcase
      end
   end

   always_comb begin
      pop        = 1'b0;
      hold_inc   = 1'b0;
      drop_valid = 1'b0;
      if (bus.rd_tick) begin
         case (state_q)
            R_IDLE: pop = !empty_q;
            R_SHOW: begin
               if (hold_q != HOLD_C) hold_inc   = 1'b1;
               else if (!empty_q)    pop        = 1'b1;
               else                  drop_valid = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      count_d = count_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         data_2_q   <= '0;
         valid_q    <= 1'b0;
         hold_q     <= '0;
      end else if (bus.flush) begin
         // data_2 keeps its last value so the display does not blank on flush
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
         hold_q     <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (bus.data_1_en && full_q) overflow_q <= 1'b1;
         if (pop) begin
            rd_ptr   <= rd_ptr + AW'(1);
            data_2_q <= rd_data;
            valid_q  <= 1'b1;
            hold_q   <= HW'(1);
         end
         if (hold_inc)   hold_q  <= hold_q + HW'(1);
         if (drop_valid) valid_q <= 1'b0;
         count_q <= count_d;
         full_q  <= (count_d == DEPTH_C);
         empty_q <= (count_d == '0);
      end
   end

   assign bus.data_2       = data_2_q;
   assign bus.data_2_valid = valid_q;
   assign bus.buffer_full  = full_q;
   assign bus.buffer_empty = empty_q;
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_data_buffer_wrapper.sv
// tb/tb_data_buffer_wrapper.sv - directed and random checks of data_buffer_wrapper against a queue model
module tb_data_buffer_wrapper;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   data_buffer_wrapper_if #(.WIDTH(16), .DEPTH(8)) bus1 ();
   data_buffer_wrapper_if #(.WIDTH(16), .DEPTH(8)) bus3 ();

   data_buffer_wrapper #(.WIDTH(16), .DEPTH(8), .HOLD_TICKS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   data_buffer_wrapper #(.WIDTH(16), .DEPTH(8), .HOLD_TICKS(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   int errors = 0;
   int checks = 0;

   logic [15:0] mq [2][$];
   logic [15:0] m_data [2];
   bit          m_valid [2];
   bit          m_ovf [2];
   int          m_age [2];
   int          hold_of [2] = '{1, 3};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mq[k].delete();
         m_data[k] = '0; m_valid[k] = 0; m_ovf[k] = 0; m_age[k] = 0;
      end
   endtask

   task automatic model_step(input logic en, input logic [15:0] d, input logic tick, input logic fl);
      for (int k = 0; k < 2; k++) begin
         bit full_pre;
         full_pre = (mq[k].size() == 8);
         if (fl) begin
            mq[k].delete();
            m_valid[k] = 0; m_ovf[k] = 0; m_age[k] = 0;
         end else begin
            if (tick) begin
               if (!m_valid[k]) begin
                  if (mq[k].size() > 0) begin
                     m_data[k] = mq[k].pop_front(); m_valid[k] = 1; m_age[k] = 1;
                  end
               end else if (m_age[k] < hold_of[k]) begin
                  m_age[k]++;
               end else if (mq[k].size() > 0) begin
                  m_data[k] = mq[k].pop_front(); m_age[k] = 1;
               end else begin
                  m_valid[k] = 0;
               end
            end
            if (en) begin
               if (full_pre) m_ovf[k] = 1;
               else          mq[k].push_back(d);
            end
         end
      end
   endtask

   task automatic check_all();
      chk("h1_data_2",  32'(bus1.data_2),       32'(m_data[0]));
      chk("h1_valid",   32'(bus1.data_2_valid), 32'(m_valid[0]));
      chk("h1_count",   32'(bus1.count),        32'(mq[0].size()));
      chk("h1_full",    32'(bus1.buffer_full),  32'(mq[0].size() == 8));
      chk("h1_empty",   32'(bus1.buffer_empty), 32'(mq[0].size() == 0));
      chk("h1_ovf",     32'(bus1.overflow),     32'(m_ovf[0]));
      chk("h3_data_2",  32'(bus3.data_2),       32'(m_data[1]));
      chk("h3_valid",   32'(bus3.data_2_valid), 32'(m_valid[1]));
      chk("h3_count",   32'(bus3.count),        32'(mq[1].size()));
      chk("h3_full",    32'(bus3.buffer_full),  32'(mq[1].size() == 8));
      chk("h3_empty",   32'(bus3.buffer_empty), 32'(mq[1].size() == 0));
      chk("h3_ovf",     32'(bus3.overflow),     32'(m_ovf[1]));
   endtask

   task automatic step(input logic en, input logic [15:0] d, input logic tick, input logic fl);
      bus1.data_1_en = en; bus1.data_1 = d; bus1.rd_tick = tick; bus1.flush = fl;
      bus3.data_1_en = en; bus3.data_1 = d; bus3.rd_tick = tick; bus3.flush = fl;
      @(posedge clk);
      #1;
      model_step(en, d, tick, fl);
      bus1.data_1_en = 0; bus1.rd_tick = 0; bus1.flush = 0;
      bus3.data_1_en = 0; bus3.rd_tick = 0; bus3.flush = 0;
      check_all();
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_empty"}, 32'(bus1.buffer_empty), 32'd1);
      chk({tag, "_full"},  32'(bus1.buffer_full),  32'd0);
      chk({tag, "_count"}, 32'(bus1.count),        32'd0);
      chk({tag, "_valid"}, 32'(bus1.data_2_valid), 32'd0);
      chk({tag, "_ovf"},   32'(bus1.overflow),     32'd0);
   endtask

   logic [15:0] fib [5] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5};

   initial begin
      bus1.data_1_en = 0; bus1.data_1 = '0; bus1.rd_tick = 0; bus1.flush = 0;
      bus3.data_1_en = 0; bus3.data_1 = '0; bus3.rd_tick = 0; bus3.flush = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("rst0");
      chk("rst0_data_2", 32'(bus1.data_2), 32'd0);
      rst = 0;

      // Fibonacci words, then drain with HOLD_TICKS=1
      for (int i = 0; i < 5; i++) step(1, fib[i], 0, 0);
      chk("fib_count", 32'(bus1.count), 32'd5);
      for (int i = 0; i < 5; i++) begin
         step(0, '0, 1, 0);
         chk("fib_word", 32'(bus1.data_2), 32'(fib[i]));
         chk("fib_valid", 32'(bus1.data_2_valid), 32'd1);
      end
      step(0, '0, 1, 0);
      chk("fib_end_valid", 32'(bus1.data_2_valid), 32'd0);
      chk("fib_end_data", 32'(bus1.data_2), 32'd5);
      chk("fib_end_empty", 32'(bus1.buffer_empty), 32'd1);

      // Fill past full; pointers start at 5 so this wraps
      for (int i = 1; i <= 9; i++) begin
         step(1, 16'(i), 0, 0);
         if (i == 8) begin
            chk("fill_full8", 32'(bus1.buffer_full), 32'd1);
            chk("fill_ovf8", 32'(bus1.overflow), 32'd0);
         end
      end
      chk("fill_count", 32'(bus1.count), 32'd8);
      chk("fill_ovf", 32'(bus1.overflow), 32'd1);

      // Write while full in the same cycle as a pop: write rejected
      step(1, 16'h0077, 1, 0);
      chk("wp_count", 32'(bus1.count), 32'd7);
      chk("wp_data", 32'(bus1.data_2), 32'd1);
      step(1, 16'h0088, 0, 0);
      chk("wp_count2", 32'(bus1.count), 32'd8);
      for (int i = 2; i <= 9; i++) begin
         step(0, '0, 1, 0);
         chk("drain_word", 32'(bus1.data_2), (i == 9) ? 32'h88 : 32'(i));
      end
      step(0, '0, 1, 0);
      chk("drain_valid", 32'(bus1.data_2_valid), 32'd0);

      // Flush with 5 stored and a word showing
      for (int i = 0; i < 6; i++) step(1, 16'(100 + i), 0, 0);
      step(0, '0, 1, 0);
      chk("fl_pre_count", 32'(bus1.count), 32'd5);
      chk("fl_pre_valid", 32'(bus1.data_2_valid), 32'd1);
      step(0, '0, 0, 1);
      chk("fl_count", 32'(bus1.count), 32'd0);
      chk("fl_empty", 32'(bus1.buffer_empty), 32'd1);
      chk("fl_valid", 32'(bus1.data_2_valid), 32'd0);
      chk("fl_data", 32'(bus1.data_2), 32'd100);
      chk("fl_ovf", 32'(bus1.overflow), 32'd0);

      // HOLD_TICKS=3: two words, each shown three ticks
      step(1, 16'h000A, 0, 0);
      step(1, 16'h000B, 0, 0);
      for (int t = 1; t <= 7; t++) begin
         step(0, '0, 1, 0);
         chk("h3_seq_valid", 32'(bus3.data_2_valid), 32'(t <= 6));
         chk("h3_seq_data", 32'(bus3.data_2), (t <= 3) ? 32'hA : 32'hB);
      end

      // Random traffic, a mid-traffic reset, then more random traffic
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 300; i++)
            step($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 9) < 3,
                 $urandom_range(0, 99) < 2);
         #1 rst = 1;
         #2;
         model_reset();
         check_reset_state("rst_mid");
         check_all();
         @(posedge clk);
         #1 rst = 0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
